// File: rtl/register_writeback_pkg.sv
// Shared register-file types: selector/data widths and the buffered write entry.
package register_writeback_pkg;

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [SEL_W-1:0]  ws;
    logic [DATA_W-1:0] wd;
  } wb_entry;

endpackage

// File: rtl/writeback_fifo.sv
// In-order circular buffer of pending register writes, with occupancy exposed for forwarding.
module writeback_fifo
  import register_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry                push_data,
  input  logic                   pop,
  output wb_entry                head,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic [PTR_W-1:0]       rd_ptr,
  output logic [DEPTH-1:0]       valid,
  output wb_entry [DEPTH-1:0]    entries
);

  wb_entry [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    valid_q;
  logic                push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // A full buffer refuses pushes even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Push and pop never target the same slot: pointers only coincide when full or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      count_q <= count_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign valid   = valid_q;
  assign entries = mem_q;

endmodule

// File: rtl/register_writeback.sv
// Register-file write initiator: buffered write requests drained onto one write port.
// Forwarding lookup is built only when REGISTER_WRITEBACK_FWD_EN is defined.
module register_writeback #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [SEL_W-1:0]       i_ws,
  input  logic [DATA_W-1:0]      i_wd,
  input  logic                   i_drain_en,
  output logic                   o_we,
  output logic [SEL_W-1:0]       o_ws,
  output logic [DATA_W-1:0]      o_wd,
  input  logic [SEL_W-1:0]       i_rs1,
  input  logic [SEL_W-1:0]       i_rs2,
  output logic                   o_fwd1_hit,
  output logic [DATA_W-1:0]      o_fwd1_data,
  output logic                   o_fwd2_hit,
  output logic [DATA_W-1:0]      o_fwd2_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  import register_writeback_pkg::wb_entry;

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry                push_data, head;
  wb_entry [DEPTH-1:0]    entries;
  logic [DEPTH-1:0]       valid;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   full, empty, pop;
  logic                   we_q;
  logic [SEL_W-1:0]       ws_q;
  logic [DATA_W-1:0]      wd_q;

  assign push_data = '{ws: i_ws, wd: i_wd};
  assign pop       = i_drain_en && !empty;

  writeback_fifo #(
    .DEPTH(DEPTH)
  ) u_writeback_fifo (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .push     (i_valid),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (o_count),
    .full     (full),
    .empty    (empty),
    .rd_ptr   (rd_ptr),
    .valid    (valid),
    .entries  (entries)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      we_q <= 1'b0;
      ws_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        ws_q <= head.ws;
        wd_q <= head.wd;
      end
    end
  end

  assign o_ready = !full;
  assign o_we    = we_q;
  assign o_ws    = ws_q;
  assign o_wd    = wd_q;
  assign o_empty = empty && !we_q;

`ifdef REGISTER_WRITEBACK_FWD_EN
  logic [PTR_W-1:0] idx;

  // Output stage has lowest priority; walking oldest to youngest lets the youngest match win.
  always_comb begin
    o_fwd1_hit  = we_q && (ws_q == i_rs1);
    o_fwd1_data = o_fwd1_hit ? wd_q : '0;
    o_fwd2_hit  = we_q && (ws_q == i_rs2);
    o_fwd2_data = o_fwd2_hit ? wd_q : '0;
    idx         = rd_ptr;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (valid[idx] && (entries[idx].ws == i_rs1)) begin
        o_fwd1_hit  = 1'b1;
        o_fwd1_data = entries[idx].wd;
      end
      if (valid[idx] && (entries[idx].ws == i_rs2)) begin
        o_fwd2_hit  = 1'b1;
        o_fwd2_data = entries[idx].wd;
      end
    end
  end
`else
  logic unused_fwd;

  assign o_fwd1_hit  = 1'b0;
  assign o_fwd1_data = '0;
  assign o_fwd2_hit  = 1'b0;
  assign o_fwd2_data = '0;
  assign unused_fwd  = ^{i_rs1, i_rs2, rd_ptr, valid, entries};
`endif

endmodule

// File: tb/tb_register_writeback.sv
// Scoreboard bench for register_writeback; forwarding expectations follow REGISTER_WRITEBACK_FWD_EN.
module tb_register_writeback;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef struct packed {
    logic [3:0]  ws;
    logic [31:0] wd;
  } ent_t;

  logic              clk;
  logic              i_reset_n;
  logic              i_valid;
  logic              o_ready;
  logic [SEL_W-1:0]  i_ws;
  logic [DATA_W-1:0] i_wd;
  logic              i_drain_en;
  logic              o_we;
  logic [SEL_W-1:0]  o_ws;
  logic [DATA_W-1:0] o_wd;
  logic [SEL_W-1:0]  i_rs1, i_rs2;
  logic              o_fwd1_hit, o_fwd2_hit;
  logic [DATA_W-1:0] o_fwd1_data, o_fwd2_data;
  logic [2:0]        o_count;
  logic              o_empty;

  register_writeback #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_ws       (i_ws),
    .i_wd       (i_wd),
    .i_drain_en (i_drain_en),
    .o_we       (o_we),
    .o_ws       (o_ws),
    .o_wd       (o_wd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .o_fwd1_hit (o_fwd1_hit),
    .o_fwd1_data(o_fwd1_data),
    .o_fwd2_hit (o_fwd2_hit),
    .o_fwd2_data(o_fwd2_data),
    .o_count    (o_count),
    .o_empty    (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mdl_q[$];
  ent_t sb_q[$];
  logic        mdl_we;
  logic [3:0]  mdl_ws;
  logic [31:0] mdl_wd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void exp_fwd(input logic [3:0] rs, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    for (int i = mdl_q.size() - 1; i >= 0; i--) begin
      if (!hit && mdl_q[i].ws == rs) begin
        hit  = 1'b1;
        data = mdl_q[i].wd;
      end
    end
    if (!hit && mdl_we && mdl_ws == rs) begin
      hit  = 1'b1;
      data = mdl_wd;
    end
`ifndef REGISTER_WRITEBACK_FWD_EN
    hit  = 1'b0;
    data = '0;
`endif
  endfunction

  task automatic check_outputs();
    logic        h;
    logic [31:0] d;
    ent_t        e;
    check("ready", o_ready, mdl_q.size() != DEPTH);
    check("count", o_count, mdl_q.size());
    check("empty", o_empty, mdl_q.size() == 0 && !mdl_we);
    check("we", o_we, mdl_we);
    check("ws", o_ws, mdl_ws);
    check("wd", o_wd, mdl_wd);
    if (o_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_pending", sb_q.size() != 0, 1'b1);
      end else begin
        e = sb_q.pop_front();
        check("sb_ws", o_ws, e.ws);
        check("sb_wd", o_wd, e.wd);
      end
    end
    exp_fwd(i_rs1, h, d);
    check("fwd1_hit", o_fwd1_hit, h);
    check("fwd1_data", o_fwd1_data, d);
    exp_fwd(i_rs2, h, d);
    check("fwd2_hit", o_fwd2_hit, h);
    check("fwd2_data", o_fwd2_data, d);
  endtask

  // Called at posedge+1; checks at posedge+4, then advances model and DUT by one edge.
  task automatic cycle(input logic v, input logic [3:0] ws, input logic [31:0] wd,
                       input logic drain);
    logic do_push, do_pop;
    ent_t e;
    i_valid    = v;
    i_ws       = ws;
    i_wd       = wd;
    i_drain_en = drain;
    #3;
    check_outputs();
    do_push = v && (mdl_q.size() != DEPTH);
    do_pop  = drain && (mdl_q.size() != 0);
    @(posedge clk);
    if (do_pop) begin
      e      = mdl_q.pop_front();
      mdl_we = 1'b1;
      mdl_ws = e.ws;
      mdl_wd = e.wd;
    end else begin
      mdl_we = 1'b0;
    end
    if (do_push) begin
      e = '{ws: ws, wd: wd};
      mdl_q.push_back(e);
      sb_q.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    i_reset_n  = 1'b0;
    i_valid    = 1'b0;
    i_drain_en = 1'b0;
    mdl_q.delete();
    sb_q.delete();
    mdl_we = 1'b0;
    mdl_ws = '0;
    mdl_wd = '0;
    #3;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_valid    = 1'b0;
    i_ws       = '0;
    i_wd       = '0;
    i_drain_en = 1'b0;
    i_rs1      = '0;
    i_rs2      = '0;
    #1;
    do_reset();
    repeat (2) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    // Single write, drained immediately
    i_rs1 = 4'd5;
    cycle(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1);
    repeat (4) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    // Fill with drain held, fifth push refused, then push while draining
    i_rs1 = 4'd2;
    i_rs2 = 4'd4;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0);
    cycle(1'b1, 4'd5, 32'h105, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(8 + i), 32'h200 + 32'(i), 1'b1);
    repeat (6) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    // Same register twice: youngest wins, then output-stage forwarding
    i_rs1 = 4'd7;
    i_rs2 = 4'd1;
    cycle(1'b1, 4'd1, 32'h33, 1'b0);
    cycle(1'b1, 4'd7, 32'h11, 1'b0);
    cycle(1'b1, 4'd7, 32'h22, 1'b0);
    repeat (2) cycle(1'b0, 4'd0, 32'h0, 1'b0);
    repeat (5) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    // Steady push+pop across pointer wrap
    cycle(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b0);
    cycle(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b0);
    for (int i = 0; i < 20; i++) begin
      i_rs1 = 4'($urandom_range(0, 15));
      i_rs2 = 4'($urandom_range(0, 15));
      cycle(1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b1);
    end
    repeat (4) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    // Pending r3 lookup on port 2
    i_rs1 = 4'd9;
    i_rs2 = 4'd3;
    cycle(1'b1, 4'd3, 32'h0000_0ABC, 1'b0);
    cycle(1'b0, 4'd0, 32'h0, 1'b0);
    repeat (3) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    // Reset while draining three entries
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(10 + i), 32'h300 + 32'(i), 1'b0);
    cycle(1'b0, 4'd0, 32'h0, 1'b1);
    do_reset();
    repeat (4) cycle(1'b0, 4'd0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
